regfile_wport_arbiter: RTL and testbench
========================================

// Module: regfile_wport_arbiter
// PURPOSE
//  Owns the single regfile write port. Shares it between the in-order WB stage and the
//  multi-cycle unit (mul/div) result path. MU results wait in a small FIFO until the port
//  is free. Keeps a busy scoreboard of regs with an outstanding MU write for ID-stage
//  interlock. Sits between WB/MU and regfile; read data from regfile passes through here.
// PARAMETERS
//  DEPTH       2   MU result FIFO entries (power of 2, >=2)
//  STARVE_MAX  4   cycles FIFO head may wait before stall_req asserts (>=1)
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  wb_we      in   1   WB stage write request (never stalled by this block)
//  wb_waddr   in   5   WB destination reg
//  wb_wdata   in   32  WB write data
//  mu_valid   in   1   MU result valid
//  mu_ready   out  1   FIFO can accept (= !full)
//  mu_waddr   in   5   MU destination reg
//  mu_wdata   in   32  MU result data
//  iss_valid  in   1   long-latency op issued this cycle
//  iss_waddr  in   5   its destination reg
//  busy       out  32  busy[i]=1: reg i has a pending MU write; busy[0] always 0
//  stall_req  out  1   ask pipeline to bubble WB so the FIFO head can drain
//  rf_we      out  1   to regfile we
//  rf_waddr   out  5   to regfile waddr
//  rf_wdata   out  32  to regfile wdata
//  rf_raddr1, rf_raddr2  in  5   read addresses (same as sent to regfile)
//  rf_rdata1, rf_rdata2  in  32  regfile read data
//  rdata1, rdata2        out 32  read data delivered to ID
// BEHAVIOUR
//  - Reset: FIFO empty, busy=0, starve count=0, FSM IDLE, stall_req=0; rf_we forced 0 while rst=1.
//  - Port free when !(wb_we && wb_waddr!=0). WB has absolute priority: a WB write is always
//    driven to rf_* same cycle (combinational, 0 latency).
//  - Push: mu_valid&&mu_ready; mu_waddr==0 -> accepted, dropped (no entry). ready from full
//    only; pop in same cycle does not enable a push when full.
//  - Pop: FIFO non-empty && port free -> rf_we=1, rf_waddr/wdata=head, pop. Entry pushed in
//    cycle N earliest written in N+1. Simultaneous push+pop on non-full FIFO: both occur.
//  - Ptrs wrap modulo DEPTH; count width clog2(DEPTH)+1.
//  - FSM: IDLE (empty) -> PEND on push. PEND: pop leaving empty -> IDLE; head blocked ->
//    cnt++; cnt reaches STARVE_MAX -> FORCE. FORCE: stall_req=1; on pop -> cnt=0, PEND or
//    IDLE. cnt clears on every pop. stall_req registered (asserts cycle after threshold).
//  - Scoreboard: iss_valid&&iss_waddr!=0 sets busy[iss_waddr]; MU pop clears busy[head addr].
//    Set and clear same reg same cycle: set wins. WB writes never change busy.
//  - rst mid-operation: FIFO contents discarded, no rf write in the reset cycle.
// CONFIGURATION
//  REGFILE_FWD_EN defined: rdataN = rf_rdataN, except when rf_we && rf_waddr==rf_raddrN &&
//   rf_raddrN!=0 -> rf_wdata (write-to-read bypass, covers WB and MU writes).
//  Not defined: rdataN = rf_rdataN pure pass-through; same-cycle write visible next cycle.
// TESTING
//  - rst=1 3 cycles with mu_valid=1 -> rf_we=0, busy=0, mu_ready=1, no writes after release.
//  - wb_we=1 waddr=5 data=0xA5A5A5A5, MU push r7=0x11 same cycle -> rf r5 now, r7 next cycle.
//  - iss r9, WB writes every cycle, MU push r9 -> stall_req after 4 blocked cycles; first
//    bubble writes r9, busy[9] 1->0, stall_req drops next cycle.
//  - DEPTH=2: push r1,r2 with WB busy -> mu_ready=0; third push held until a pop occurs.
//  - iss r3 in same cycle as MU pop of r3 -> busy[3] stays 1; MU push to r0 -> no rf write.
//  - REGFILE_FWD_EN: write r4=0xDEAD, raddr1=4 same cycle -> rdata1=0xDEAD; without macro old value.

Source files
------------

// File: rtl/regfile_wport_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wport_arbiter_if
// Brief    : WB / MU / issue / regfile-port bundle for regfile_wport_arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface regfile_wport_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        mu_valid;
    logic        mu_ready;
    logic [4:0]  mu_waddr;
    logic [31:0] mu_wdata;
    logic        iss_valid;
    logic [4:0]  iss_waddr;
    logic [31:0] busy;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    modport slave (
        input  wb_we, wb_waddr, wb_wdata,
        input  mu_valid, mu_waddr, mu_wdata,
        output mu_ready,
        input  iss_valid, iss_waddr,
        output busy, stall_req,
        output rf_we, rf_waddr, rf_wdata,
        input  rf_raddr1, rf_raddr2, rf_rdata1, rf_rdata2,
        output rdata1, rdata2
    );

    modport master (
        output wb_we, wb_waddr, wb_wdata,
        output mu_valid, mu_waddr, mu_wdata,
        input  mu_ready,
        output iss_valid, iss_waddr,
        input  busy, stall_req,
        input  rf_we, rf_waddr, rf_wdata,
        output rf_raddr1, rf_raddr2, rf_rdata1, rf_rdata2,
        input  rdata1, rdata2
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wport_arbiter
// Brief    : Shares the regfile write port between WB (priority) and a MU result
//            FIFO; keeps a pending-write scoreboard. Option: REGFILE_FWD_EN.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    regfile_wport_arbiter_if.slave  bus
);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int STV_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] C_STV_LAST = STV_W'(STARVE_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    logic [4:0]       addr_q [DEPTH];
    logic [4:0]       addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      busy_q, busy_d;
    logic [STV_W-1:0] stv_q, stv_d;
    state_t           state_q, state_d;
    logic             stall_q, stall_d;

    logic             w_wb_active;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [4:0]       w_head_addr;
    logic [31:0]      w_head_data;
    logic             w_rf_we;
    logic [4:0]       w_rf_waddr;
    logic [31:0]      w_rf_wdata;

    // A WB write to r0 is a no-op, so it leaves the port free for the FIFO head.
    always_comb begin
        w_wb_active = bus.wb_we && (bus.wb_waddr != 5'd0);
        w_full      = (count_q == C_FULL);
        w_empty     = (count_q == '0);
        w_push      = !rst && bus.mu_valid && !w_full && (bus.mu_waddr != 5'd0);
        w_pop       = !rst && !w_empty && !w_wb_active;
        w_head_addr = addr_q[rd_ptr_q];
        w_head_data = data_q[rd_ptr_q];
        w_rf_we     = !rst && (w_wb_active || w_pop);
        w_rf_waddr  = w_wb_active ? bus.wb_waddr : w_head_addr;
        w_rf_wdata  = w_wb_active ? bus.wb_wdata : w_head_data;
    end

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            addr_d[wr_ptr_q] = bus.mu_waddr;
            data_d[wr_ptr_q] = bus.mu_wdata;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    // Issue-set is applied after pop-clear so a same-register collision stays busy.
    always_comb begin
        busy_d = busy_q;
        if (w_pop) begin
            busy_d[w_head_addr] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_waddr != 5'd0)) begin
            busy_d[bus.iss_waddr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        stv_d   = stv_q;
        case (state_q)
            ST_IDLE: begin
                stv_d = '0;
                if (w_push) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (w_pop) begin
                    stv_d   = '0;
                    state_d = (count_d == '0) ? ST_IDLE : ST_PEND;
                end else begin
                    stv_d = stv_q + STV_W'(1);
                    if (stv_q == C_STV_LAST) begin
                        state_d = ST_FORCE;
                    end
                end
            end
            ST_FORCE: begin
                if (w_pop) begin
                    stv_d   = '0;
                    state_d = (count_d == '0) ? ST_IDLE : ST_PEND;
                end
            end
            default: begin
                stv_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        stall_d = (state_d == ST_FORCE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '{default: '0};
            data_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            stv_q    <= '0;
            state_q  <= ST_IDLE;
            stall_q  <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            stv_q    <= stv_d;
            state_q  <= state_d;
            stall_q  <= stall_d;
        end
    end

    always_comb begin
        bus.mu_ready  = !w_full;
        bus.busy      = busy_q;
        bus.stall_req = stall_q;
        bus.rf_we     = w_rf_we;
        bus.rf_waddr  = w_rf_waddr;
        bus.rf_wdata  = w_rf_wdata;
`ifdef REGFILE_FWD_EN
        bus.rdata1 = (w_rf_we && (w_rf_waddr == bus.rf_raddr1) && (bus.rf_raddr1 != 5'd0))
                     ? w_rf_wdata : bus.rf_rdata1;
        bus.rdata2 = (w_rf_we && (w_rf_waddr == bus.rf_raddr2) && (bus.rf_raddr2 != 5'd0))
                     ? w_rf_wdata : bus.rf_rdata2;
`else
        bus.rdata1 = bus.rf_rdata1;
        bus.rdata2 = bus.rf_rdata2;
`endif
    end
endmodule
`default_nettype wire

// File: tb/tb_regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wport_arbiter
// Brief    : Directed bench with a queue-based reference model and regfile array.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wport_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;
`ifdef REGFILE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wport_arbiter_if ifc();

    regfile_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rf_mem [32];
    ent_t        mq [$];
    logic [31:0] mbusy   = '0;
    int          mwait   = 0;
    bit          mstall  = 1'b0;
    bit          started = 1'b0;

    assign ifc.rf_rdata1 = rf_mem[ifc.rf_raddr1];
    assign ifc.rf_rdata2 = rf_mem[ifc.rf_raddr2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: checks outputs, then advances to the state after the coming posedge.
    always @(negedge clk) begin
        bit          wb_act, pop, push, ewe;
        logic [4:0]  ea;
        logic [31:0] ed, er1, er2;
        wb_act = ifc.wb_we && (ifc.wb_waddr != 5'd0);
        pop    = !rst && (mq.size() > 0) && !wb_act;
        push   = !rst && ifc.mu_valid && (mq.size() < DEPTH) && (ifc.mu_waddr != 5'd0);
        ewe    = !rst && (wb_act || pop);
        ea     = wb_act ? ifc.wb_waddr : (pop ? mq[0].a : 5'd0);
        ed     = wb_act ? ifc.wb_wdata : (pop ? mq[0].d : 32'd0);
        er1    = (FWD && ewe && ea == ifc.rf_raddr1 && ifc.rf_raddr1 != 0) ? ed : rf_mem[ifc.rf_raddr1];
        er2    = (FWD && ewe && ea == ifc.rf_raddr2 && ifc.rf_raddr2 != 0) ? ed : rf_mem[ifc.rf_raddr2];
        if (started) begin
            chk("m_rf_we", 32'(ifc.rf_we), 32'(ewe));
            if (ewe) begin
                chk("m_rf_waddr", 32'(ifc.rf_waddr), 32'(ea));
                chk("m_rf_wdata", ifc.rf_wdata, ed);
            end
            chk("m_mu_ready", 32'(ifc.mu_ready), 32'(mq.size() < DEPTH));
            chk("m_busy", ifc.busy, mbusy);
            chk("m_stall_req", 32'(ifc.stall_req), 32'(mstall));
            chk("m_rdata1", ifc.rdata1, er1);
            chk("m_rdata2", ifc.rdata2, er2);
        end
        if (rst) begin
            mq.delete();
            mbusy   = '0;
            mwait   = 0;
            mstall  = 1'b0;
            started = 1'b1;
        end else begin
            if (ewe && ea != 5'd0) rf_mem[ea] = ed;
            if (pop) mbusy[mq[0].a] = 1'b0;
            if (ifc.iss_valid && ifc.iss_waddr != 5'd0) mbusy[ifc.iss_waddr] = 1'b1;
            if (pop) begin
                void'(mq.pop_front());
                mwait = 0;
            end else if (mq.size() > 0) begin
                mwait++;
            end
            if (push) mq.push_back('{a: ifc.mu_waddr, d: ifc.mu_wdata});
            mstall = (mq.size() > 0) && (mwait >= STARVE_MAX);
        end
    end

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clr();
        ifc.wb_we     = 1'b0;
        ifc.wb_waddr  = '0;
        ifc.wb_wdata  = '0;
        ifc.mu_valid  = 1'b0;
        ifc.mu_waddr  = '0;
        ifc.mu_wdata  = '0;
        ifc.iss_valid = 1'b0;
        ifc.iss_waddr = '0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        ifc.wb_we    = 1'b1;
        ifc.wb_waddr = a;
        ifc.wb_wdata = d;
    endtask

    task automatic mu(input logic [4:0] a, input logic [31:0] d);
        ifc.mu_valid = 1'b1;
        ifc.mu_waddr = a;
        ifc.mu_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        clr();
        ifc.rf_raddr1 = '0;
        ifc.rf_raddr2 = '0;

        // Reset held three cycles with a pending MU request
        rst = 1'b1;
        mu(5'd3, 32'h33);
        nx(); nx();
        settle();
        chk("rst_rf_we", 32'(ifc.rf_we), 32'd0);
        chk("rst_mu_ready", 32'(ifc.mu_ready), 32'd1);
        chk("rst_busy", ifc.busy, 32'd0);
        chk("rst_stall", 32'(ifc.stall_req), 32'd0);
        nx();
        rst = 1'b0;
        clr();
        settle();
        chk("post_rst_no_write", 32'(ifc.rf_we), 32'd0);
        nx();

        // WB write and MU push in the same cycle
        wb(5'd5, 32'hA5A5A5A5);
        mu(5'd7, 32'h11);
        settle();
        chk("wb_now_we", 32'(ifc.rf_we), 32'd1);
        chk("wb_now_addr", 32'(ifc.rf_waddr), 32'd5);
        chk("wb_now_data", ifc.rf_wdata, 32'hA5A5A5A5);
        nx();
        clr();
        settle();
        chk("mu_next_we", 32'(ifc.rf_we), 32'd1);
        chk("mu_next_addr", 32'(ifc.rf_waddr), 32'd7);
        chk("mu_next_data", ifc.rf_wdata, 32'h11);
        nx();
        wb(5'd4, 32'h1234);
        nx();
        clr();

        // Starvation: head blocked by continuous WB traffic
        ifc.iss_valid = 1'b1;
        ifc.iss_waddr = 5'd9;
        nx();
        clr();
        settle();
        chk("iss_busy9", 32'(ifc.busy[9]), 32'd1);
        wb(5'd10, 32'h100);
        mu(5'd9, 32'h99);
        nx();
        clr();
        for (int k = 1; k <= STARVE_MAX; k++) begin
            wb(5'd10, 32'h100 + 32'(k));
            settle();
            chk("stv_no_stall_yet", 32'(ifc.stall_req), 32'd0);
            nx();
        end
        clr();
        settle();
        chk("stv_stall_on", 32'(ifc.stall_req), 32'd1);
        chk("stv_bubble_addr", 32'(ifc.rf_waddr), 32'd9);
        chk("stv_bubble_data", ifc.rf_wdata, 32'h99);
        nx();
        settle();
        chk("stv_stall_off", 32'(ifc.stall_req), 32'd0);
        chk("stv_busy9_clr", 32'(ifc.busy[9]), 32'd0);
        nx();

        // FIFO full: ready depends on fullness only
        wb(5'd11, 32'hB0);
        mu(5'd1, 32'h101);
        nx();
        mu(5'd2, 32'h102);
        nx();
        mu(5'd3, 32'h103);
        settle();
        chk("full_ready0_a", 32'(ifc.mu_ready), 32'd0);
        nx();
        ifc.wb_we = 1'b0;
        settle();
        chk("full_ready0_pop", 32'(ifc.mu_ready), 32'd0);
        chk("full_pop_addr", 32'(ifc.rf_waddr), 32'd1);
        nx();
        settle();
        chk("full_ready1", 32'(ifc.mu_ready), 32'd1);
        chk("full_pop2_addr", 32'(ifc.rf_waddr), 32'd2);
        nx();
        clr();
        settle();
        chk("full_r3_addr", 32'(ifc.rf_waddr), 32'd3);
        chk("full_r3_data", ifc.rf_wdata, 32'h103);
        nx();

        // Issue set collides with pop clear on r3; MU push to r0
        ifc.iss_valid = 1'b1;
        ifc.iss_waddr = 5'd3;
        wb(5'd12, 32'hC0);
        mu(5'd3, 32'h333);
        nx();
        clr();
        ifc.iss_valid = 1'b1;
        ifc.iss_waddr = 5'd3;
        settle();
        chk("coll_pop_addr", 32'(ifc.rf_waddr), 32'd3);
        nx();
        clr();
        settle();
        chk("coll_busy3", 32'(ifc.busy[3]), 32'd1);
        mu(5'd0, 32'hDEADBEEF);
        nx();
        clr();
        settle();
        chk("r0_push_dropped", 32'(ifc.rf_we), 32'd0);
        nx();

        // Write-to-read bypass on r4
        wb(5'd4, 32'hDEAD);
        ifc.rf_raddr1 = 5'd4;
        settle();
        chk("fwd_same_cycle", ifc.rdata1, FWD ? 32'hDEAD : 32'h1234);
        nx();
        clr();
        settle();
        chk("fwd_next_cycle", ifc.rdata1, 32'hDEAD);
        nx();

        // Reset mid-operation discards queued results
        wb(5'd13, 32'hD0);
        mu(5'd14, 32'h14);
        nx();
        mu(5'd15, 32'h15);
        nx();
        ifc.mu_valid = 1'b0;
        rst = 1'b1;
        settle();
        chk("midrst_no_write", 32'(ifc.rf_we), 32'd0);
        nx();
        rst = 1'b0;
        clr();
        settle();
        chk("midrst_discard", 32'(ifc.rf_we), 32'd0);
        chk("midrst_busy", ifc.busy, 32'd0);
        nx();

        // Mixed traffic pattern, model-checked every cycle
        for (int i = 0; i < 24; i++) begin
            ifc.wb_we     = (i % 3) != 0;
            ifc.wb_waddr  = 5'(i % 8);
            ifc.wb_wdata  = 32'h5000 + 32'(i);
            ifc.mu_valid  = (i % 2) == 0;
            ifc.mu_waddr  = 5'((i * 3) % 32);
            ifc.mu_wdata  = 32'h7000 + 32'(i);
            ifc.iss_valid = (i % 5) == 0;
            ifc.iss_waddr = 5'((i + 11) % 32);
            ifc.rf_raddr1 = 5'(i % 8);
            ifc.rf_raddr2 = 5'((i * 3) % 32);
            nx();
        end
        clr();
        for (int i = 0; i < 6; i++) nx();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
